// File: rtl/uart_dbg_pkg.sv
// Shared constants and types for the serial debug unit.
// Used by the uart_tx arbiter and its round-robin picker.
package uart_dbg_pkg;

  localparam int BYTE_W      = 8;
  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // A disabled timeout (0) still needs a 1-bit counter to keep the vectors legal.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: searches from last_winner+1
// upward with wrap-around and returns the first set request.
module rr_pick
  import uart_dbg_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Rotating first-one search starting just after the previous winner
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found_s  = 1'b0;
    cand_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = IDX_W'((int'(last_winner) + k) % N_REQ);
      if (!found_s && req[cand_s]) begin
        found_s      = 1'b1;
        pick[cand_s] = 1'b1;
        pick_idx     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of uart_tx: one requester owns the byte
// channel until its last byte, with an idle timeout to reclaim a stalled owner.
module uart_tx_arbiter
  import uart_dbg_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [N_REQ-1:0]        grant,
  output logic [BYTE_W-1:0]       d_tx,
  output logic                    vld_tx,
  input  logic                    rdy_tx,
  output logic                    busy,
  output logic                    timeout_evt
);

  localparam int               IDX_W     = $clog2(N_REQ);
  localparam int               CNT_W     = cnt_width(TIMEOUT);
  localparam bit               TMO_EN    = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [IDX_W-1:0] IDX_RST   = IDX_W'(N_REQ - 1);

  arb_state_e         state_r;
  arb_state_e         state_nxt_s;
  logic [N_REQ-1:0]   grant_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   last_winner_r;
  logic [CNT_W-1:0]   idle_cnt_r;

  logic [N_REQ-1:0]   pick_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic               lock_s;
  logic               own_vld_s;
  logic               own_last_s;
  logic [BYTE_W-1:0]  own_data_s;
  logic               end_pkt_s;
  logic               tmo_hit_s;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req        (req_vld),
    .last_winner(last_winner_r),
    .pick       (pick_s),
    .pick_idx   (pick_idx_s),
    .any        (pick_any_s)
  );

  // Owner datapath mux and end-of-packet / timeout decode
  always_comb begin
    lock_s     = (state_r == ARB_LOCK);
    own_vld_s  = req_vld[owner_r];
    own_last_s = req_last[owner_r];
    own_data_s = req_data[BYTE_W*owner_r +: BYTE_W];
    if (lock_s) begin
      vld_tx  = own_vld_s;
      d_tx    = own_data_s;
      req_rdy = grant_r & {N_REQ{rdy_tx}};
    end else begin
      vld_tx  = 1'b0;
      d_tx    = '0;
      req_rdy = '0;
    end
    end_pkt_s = lock_s && own_vld_s && rdy_tx && own_last_s;
    // A rising valid on the limit cycle wins: the counter clears instead.
    tmo_hit_s = TMO_EN && lock_s && !own_vld_s && (idle_cnt_r == CNT_LIMIT);
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = ARB_LOCK;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_LOCK: begin
        if (end_pkt_s || tmo_hit_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_LOCK;
        end
      end
      default: state_nxt_s = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant, owner index, round-robin pointer and idle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r       <= '0;
      owner_r       <= '0;
      last_winner_r <= IDX_RST;
      idle_cnt_r    <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pick_any_s) begin
            grant_r    <= pick_s;
            owner_r    <= pick_idx_s;
            idle_cnt_r <= '0;
          end else begin
            grant_r    <= '0;
          end
        end
        ARB_LOCK: begin
          if (end_pkt_s || tmo_hit_s) begin
            grant_r       <= '0;
            last_winner_r <= owner_r;
            idle_cnt_r    <= '0;
          end else if (own_vld_s) begin
            idle_cnt_r <= '0;
          end else if (idle_cnt_r != CNT_MAX) begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
          end else begin
            idle_cnt_r <= idle_cnt_r;
          end
        end
        default: begin
          grant_r    <= '0;
          idle_cnt_r <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign busy        = lock_s;
  assign timeout_evt = tmo_hit_s;

endmodule
